// File: rtl/cpu_pkg.sv
// Shared CPU-side types and default widths for the instruction memory slice.
package cpu_pkg;

  localparam int CPU_INSTR_W     = 32;
  localparam int CPU_IMEM_ADDR_W = 16;

  typedef enum logic {LOAD, RUN} imem_state_t;

endpackage

// File: rtl/cpu_imem_ram.sv
// Single-write, single-read synchronous RAM with a registered read port.
module cpu_imem_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16384,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/cpu_imem_loader.sv
// Instruction memory filled by a byte-stream boot loader, then served to the
// CPU fetch stage with one-cycle registered latency and error reporting.
module cpu_imem_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_W      = CPU_IMEM_ADDR_W,
  parameter int INSTR_W     = CPU_INSTR_W,
  parameter int DEPTH_BYTES = 65536
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ld_start,
  input  logic               ld_valid,
  input  logic [7:0]         ld_data,
  input  logic               ld_last,
  output logic               ld_ready,
  output logic               load_done,
  input  logic               fetch_req,
  input  logic [ADDR_W-1:0]  fetch_addr,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic               err
);

  localparam int BPW    = INSTR_W / 8;
  localparam int WORDS  = DEPTH_BYTES / BPW;
  localparam int WA_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int PTR_W  = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  localparam int OFF_SH = $clog2(BPW);

  imem_state_t        state;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   off;
  logic [INSTR_W-1:0] pack;
  logic [INSTR_W-1:0] pack_nxt;
  logic               accept;
  logic               word_end;
  logic               ptr_full;
  logic               wr_en;
  logic [WA_W-1:0]    wr_addr;
  logic               misaligned;
  logic               out_of_range;
  logic               req_bad;
  logic               rd_en;
  logic [WA_W-1:0]    rd_addr;
  logic [INSTR_W-1:0] rd_data;

  always_comb begin
    accept   = (state == LOAD) && ld_valid && ld_ready;
    off      = ptr & PTR_W'(BPW - 1);
    word_end = (off == PTR_W'(BPW - 1)) || ld_last;
    ptr_full = (ptr == PTR_W'(DEPTH_BYTES - 1));
    // Lowest byte address lands in the most significant lane.
    pack_nxt = pack;
    for (int unsigned b = 0; b < BPW; b++) begin
      if (off == PTR_W'(b)) pack_nxt[INSTR_W-1-8*b -: 8] = ld_data;
    end
    wr_en   = accept && word_end;
    wr_addr = WA_W'(ptr >> OFF_SH);

    misaligned   = (fetch_addr & ADDR_W'(BPW - 1)) != '0;
    out_of_range = {1'b0, fetch_addr} >= (ADDR_W+1)'(DEPTH_BYTES);
    req_bad      = misaligned || out_of_range || !load_done;
    rd_en        = fetch_req && !req_bad;
    rd_addr      = WA_W'(fetch_addr >> OFF_SH);

    instr = (instr_valid && !err) ? rd_data : '0;
  end

  cpu_imem_ram #(
    .WIDTH(INSTR_W),
    .DEPTH(WORDS)
  ) u_ram (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(pack_nxt),
    .rd_en  (rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= LOAD;
      ptr         <= '0;
      pack        <= '0;
      ld_ready    <= 1'b0;
      load_done   <= 1'b0;
      instr_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      instr_valid <= fetch_req;
      err         <= fetch_req && req_bad;
      case (state)
        LOAD: begin
          load_done <= 1'b0;
          ld_ready  <= 1'b1;
          if (accept) begin
            ptr  <= ptr + PTR_W'(1);
            pack <= word_end ? '0 : pack_nxt;
            if (ld_last || ptr_full) begin
              state    <= RUN;
              ld_ready <= 1'b0;
            end
          end
        end
        RUN: begin
          ld_ready <= 1'b0;
          if (ld_start) begin
            state     <= LOAD;
            ptr       <= '0;
            pack      <= '0;
            load_done <= 1'b0;
            ld_ready  <= 1'b1;
          end else begin
            load_done <= 1'b1;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_imem_loader.sv
// Bench for cpu_imem_loader: a 64-byte and a 16-byte instance driven by
// directed loads/fetches, checked against a byte-level image model every cycle.
module tb_cpu_imem_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        ld_start[2], ld_valid[2], ld_last[2], ld_ready[2], load_done[2];
  logic        fetch_req[2], instr_valid[2], err[2];
  logic [7:0]  ld_data[2];
  logic [15:0] fetch_addr[2];
  logic [31:0] instr[2];

  int total = 0;
  int bad   = 0;

  cpu_imem_loader #(.ADDR_W(16), .INSTR_W(32), .DEPTH_BYTES(64)) dut0 (
    .clk(clk), .rst_n(rst_n), .ld_start(ld_start[0]), .ld_valid(ld_valid[0]),
    .ld_data(ld_data[0]), .ld_last(ld_last[0]), .ld_ready(ld_ready[0]),
    .load_done(load_done[0]), .fetch_req(fetch_req[0]), .fetch_addr(fetch_addr[0]),
    .instr(instr[0]), .instr_valid(instr_valid[0]), .err(err[0]));

  cpu_imem_loader #(.ADDR_W(16), .INSTR_W(32), .DEPTH_BYTES(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .ld_start(ld_start[1]), .ld_valid(ld_valid[1]),
    .ld_data(ld_data[1]), .ld_last(ld_last[1]), .ld_ready(ld_ready[1]),
    .load_done(load_done[1]), .fetch_req(fetch_req[1]), .fetch_addr(fetch_addr[1]),
    .instr(instr[1]), .instr_valid(instr_valid[1]), .err(err[1]));

  task automatic chk(input string name, input int i, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s dut%0d got=%h want=%h", name, i, got, want);
    end
  endtask

  // Image model: byte-addressed contents plus loader/fetch expectations.
  int unsigned dep[2] = '{64, 16};
  byte unsigned mb[2][64];
  byte unsigned pend[2][4];
  bit          m_load[2], m_ready[2], m_done[2], m_fv[2], m_ferr[2];
  int unsigned m_ptr[2];
  logic [31:0] m_finstr[2];

  always @(posedge clk or negedge rst_n) begin
    int unsigned a, k, base;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_load[i] = 1; m_ptr[i] = 0; m_ready[i] = 0; m_done[i] = 0;
        m_fv[i] = 0; m_ferr[i] = 0; m_finstr[i] = '0;
        for (int j = 0; j < 4; j++) pend[i][j] = 0;
      end else begin
        m_fv[i] = fetch_req[i];
        m_ferr[i] = 0;
        m_finstr[i] = '0;
        if (fetch_req[i]) begin
          a = fetch_addr[i];
          if (a % 4 != 0 || a >= dep[i] || !m_done[i]) m_ferr[i] = 1;
          else m_finstr[i] = {mb[i][a], mb[i][a+1], mb[i][a+2], mb[i][a+3]};
        end
        if (m_load[i]) begin
          if (ld_valid[i] && m_ready[i]) begin
            k = m_ptr[i] % 4;
            base = m_ptr[i] - k;
            pend[i][k] = ld_data[i];
            if (k == 3 || ld_last[i]) begin
              for (int j = 0; j < 4; j++) mb[i][base+j] = (j <= k) ? pend[i][j] : 8'h00;
              for (int j = 0; j < 4; j++) pend[i][j] = 0;
            end
            if (ld_last[i] || m_ptr[i] == dep[i] - 1) m_load[i] = 0;
            m_ptr[i]++;
          end
          m_ready[i] = m_load[i];
          m_done[i] = 0;
        end else if (ld_start[i]) begin
          m_load[i] = 1; m_ptr[i] = 0; m_ready[i] = 1; m_done[i] = 0;
        end else begin
          m_ready[i] = 0; m_done[i] = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        chk("m_ld_ready", i, ld_ready[i], m_ready[i]);
        chk("m_load_done", i, load_done[i], m_done[i]);
        chk("m_instr_valid", i, instr_valid[i], m_fv[i]);
        if (m_fv[i]) begin
          chk("m_err", i, err[i], m_ferr[i]);
          chk("m_instr", i, instr[i], m_finstr[i]);
        end
      end
    end
  end

  task automatic send_byte(input int i, input logic [7:0] d, input logic last);
    bit r;
    ld_valid[i] = 1; ld_data[i] = d; ld_last[i] = last;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); r = ld_ready[i];
      @(posedge clk); #1;
      if (r) begin
        ld_valid[i] = 0; ld_last[i] = 0;
        return;
      end
    end
    ld_valid[i] = 0; ld_last[i] = 0;
    total++; bad++;
    $display("FAIL send_timeout dut%0d byte=%h not accepted", i, d);
  endtask

  task automatic wait_done(input int i);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (load_done[i]) break;
    end
    chk("wait_done", i, load_done[i], 1);
    @(posedge clk); #1;
  endtask

  task automatic fetch_chk(input int i, input logic [15:0] a, input logic e,
                           input logic [31:0] w, input string nm);
    fetch_req[i] = 1; fetch_addr[i] = a;
    @(posedge clk); #1;
    fetch_req[i] = 0;
    @(negedge clk);
    chk({nm, "_valid"}, i, instr_valid[i], 1);
    chk({nm, "_err"}, i, err[i], e);
    chk({nm, "_instr"}, i, instr[i], w);
    @(posedge clk); #1;
  endtask

  task automatic pulse_start(input int i);
    ld_start[i] = 1;
    @(posedge clk); #1;
    ld_start[i] = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout bench did not finish");
    $fatal(1);
  end

  initial begin
    int acc;
    int n;
    for (int i = 0; i < 2; i++) begin
      ld_start[i] = 0; ld_valid[i] = 0; ld_last[i] = 0; ld_data[i] = '0;
      fetch_req[i] = 0; fetch_addr[i] = '0;
    end

    @(negedge clk);
    chk("rst_ready", 0, ld_ready[0], 0);
    chk("rst_done", 0, load_done[0], 0);
    chk("rst_valid", 0, instr_valid[0], 0);
    chk("rst_err", 0, err[0], 0);
    chk("rst_instr", 0, instr[0], 32'h0);
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    chk("ready_first", 0, ld_ready[0], 0);
    @(posedge clk); #1;

    // Basic load and fetch
    for (int b = 0; b < 8; b++) send_byte(0, 8'(8'h11 + b), b == 7);
    @(negedge clk); chk("done_lag1", 0, load_done[0], 0);
    @(negedge clk); chk("done_lag2", 0, load_done[0], 1);
    @(posedge clk); #1;
    fetch_chk(0, 16'h0000, 0, 32'h11121314, "t1_w0");
    fetch_chk(0, 16'h0004, 0, 32'h15161718, "t1_w1");

    // Misaligned / out of range, then back-to-back stream checked by the model
    fetch_chk(0, 16'h0002, 1, 32'h0, "t2_misal");
    fetch_chk(0, 16'h0040, 1, 32'h0, "t2_oor");
    fetch_req[0] = 1;
    for (int k = 0; k < 4; k++) begin
      fetch_addr[0] = 16'((k % 2) * 4 + (k == 3 ? 1 : 0));
      @(posedge clk); #1;
    end
    fetch_req[0] = 0;

    // Partial final word
    pulse_start(0);
    send_byte(0, 8'hAA, 0);
    send_byte(0, 8'hBB, 0);
    send_byte(0, 8'hCC, 1);
    wait_done(0);
    fetch_chk(0, 16'h0000, 0, 32'hAABBCC00, "t3_part");
    fetch_chk(0, 16'h0004, 0, 32'h15161718, "t3_keep");

    // Early fetch and overflow on the 16-byte instance
    fetch_chk(1, 16'h0000, 1, 32'h0, "t4_early");
    acc = 0; n = 1;
    for (int c = 0; c < 25 && n <= 20; c++) begin
      bit r;
      ld_valid[1] = 1; ld_data[1] = 8'(n);
      @(negedge clk); r = ld_ready[1];
      @(posedge clk); #1;
      if (r) begin acc++; n++; end
    end
    ld_valid[1] = 0;
    chk("t4_accepted", 1, 32'(acc), 32'd16);
    wait_done(1);
    fetch_chk(1, 16'h000C, 0, 32'h0D0E0F10, "t4_last");
    fetch_chk(1, 16'h0010, 1, 32'h0, "t4_oor");

    // Reset mid-load
    pulse_start(0);
    for (int b = 0; b < 6; b++) send_byte(0, 8'(8'h21 + b), 0);
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    for (int b = 0; b < 4; b++) send_byte(0, 8'(8'h01 + b), b == 3);
    wait_done(0);
    fetch_chk(0, 16'h0000, 0, 32'h01020304, "t5_new");
    fetch_chk(0, 16'h0004, 0, 32'h15161718, "t5_old");

    // Reload with concurrent fetch
    ld_start[0] = 1; fetch_req[0] = 1; fetch_addr[0] = 16'h0000;
    @(posedge clk); #1;
    ld_start[0] = 0; fetch_req[0] = 0;
    @(negedge clk);
    chk("t6_valid", 0, instr_valid[0], 1);
    chk("t6_err", 0, err[0], 0);
    chk("t6_instr", 0, instr[0], 32'h01020304);
    chk("t6_done", 0, load_done[0], 0);
    chk("t6_ready", 0, ld_ready[0], 1);
    @(posedge clk); #1;
    send_byte(0, 8'h55, 0);
    send_byte(0, 8'h66, 0);
    send_byte(0, 8'h77, 0);
    send_byte(0, 8'h88, 1);
    wait_done(0);
    fetch_chk(0, 16'h0000, 0, 32'h55667788, "t6_new");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
